// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for the nanoprocessor. It holds the fetch address and
// updates it from strobes issued by the control sequencer. Supported actions
// are increment, absolute load, relative branch, call (push return address)
// and return (pop). Overflow and underflow of the return stack raise sticky
// error flags.
//
// Optional feature macro: PC_REL_BRANCH_EN
//   defined   : i_br_rel / i_offset perform a PC-relative branch
//   undefined : i_br_rel / i_offset are ignored (ports kept, inputs unused)
//
// Parameters
//   ADDR_W      : PC and return-address width (>= 2)
//   STACK_DEPTH : number of return-address entries (>= 1)
//   OFF_W       : signed branch offset width (<= ADDR_W)
//
// Ports
//   clk             in   clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   i_inc_pc        in   pc <= pc + 1
//   i_load_pc       in   pc <= i_data_in
//   i_br_rel        in   pc <= pc + sign-extended i_offset
//   i_call          in   push pc + 1, pc <= i_data_in
//   i_ret           in   pc <= popped return address
//   i_data_in       in   jump / call target
//   i_offset        in   signed branch offset
//   i_err_clr       in   clears the sticky stack error flags
//   o_pc            out  current program counter
//   o_sp            out  number of valid stack entries
//   o_stack_empty   out  o_sp == 0
//   o_stack_full    out  o_sp == STACK_DEPTH
//   o_stk_ovf       out  sticky: call issued while full
//   o_stk_unf       out  sticky: ret issued while empty
//
// Strobe priority: ret > call > load_pc > br_rel > inc_pc.
// -----------------------------------------------------------------------------
module pc_stack_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int OFF_W       = 6,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_inc_pc,
  input  logic              i_load_pc,
  input  logic              i_br_rel,
  input  logic              i_call,
  input  logic              i_ret,
  input  logic [ADDR_W-1:0] i_data_in,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic              i_err_clr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [SP_W-1:0]   o_sp,
  output logic              o_stack_empty,
  output logic              o_stack_full,
  output logic              o_stk_ovf,
  output logic              o_stk_unf
);

  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_stk_ovf;
  logic              r_stk_unf;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_br;
  logic              w_br_en;
  logic              w_push;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;

  assign w_empty  = (r_sp == '0);
  assign w_full   = (r_sp == SP_W'(STACK_DEPTH));
  assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef PC_REL_BRANCH_EN
  logic [ADDR_W-1:0] w_off_ext;
  // Size cast of a signed operand sign-extends; works for OFF_W == ADDR_W too.
  assign w_off_ext = ADDR_W'($signed(i_offset));
  assign w_pc_br   = r_pc + w_off_ext;
  assign w_br_en   = i_br_rel;
`else
  logic w_unused_br;
  assign w_unused_br = ^{i_br_rel, i_offset};
  assign w_pc_br     = r_pc;
  assign w_br_en     = 1'b0;
`endif

  // A call only pushes when ret does not win the cycle and there is room.
  assign w_push    = i_call & ~i_ret & ~w_full;
  assign w_ovf_evt = i_call & ~i_ret &  w_full;
  assign w_unf_evt = i_ret  & w_empty;

  // Slots are only addressed with sp < STACK_DEPTH (push) or sp > 0 (pop),
  // so truncating to the index width never aliases.
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= '0;
      r_sp      <= '0;
      r_stk_ovf <= 1'b0;
      r_stk_unf <= 1'b0;
    end else begin
      if (i_ret) begin
        if (!w_empty) begin
          r_pc <= r_stack[w_pop_idx];
          r_sp <= r_sp - SP_W'(1);
        end
      end else if (i_call) begin
        r_pc <= i_data_in;
        if (!w_full) begin
          r_sp <= r_sp + SP_W'(1);
        end
      end else if (i_load_pc) begin
        r_pc <= i_data_in;
      end else if (w_br_en) begin
        r_pc <= w_pc_br;
      end else if (i_inc_pc) begin
        r_pc <= w_pc_inc;
      end

      // A new error event beats a simultaneous clear.
      r_stk_ovf <= w_ovf_evt | (r_stk_ovf & ~i_err_clr);
      r_stk_unf <= w_unf_evt | (r_stk_unf & ~i_err_clr);
    end
  end

  // Stack storage needs no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (w_push && reset_n) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign o_pc          = r_pc;
  assign o_sp          = r_sp;
  assign o_stack_empty = w_empty;
  assign o_stack_full  = w_full;
  assign o_stk_ovf     = r_stk_ovf;
  assign o_stk_unf     = r_stk_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_stack_unit
//
// Scoreboard bench for pc_stack_unit with default parameters
// (ADDR_W=8, STACK_DEPTH=4, OFF_W=6). The driver issues one strobe set per
// cycle and queues the state expected after the following rising edge; the
// monitor pops and compares on each falling edge (or on demand for the
// asynchronous reset check). Branch expectations follow PC_REL_BRANCH_EN.
// -----------------------------------------------------------------------------
module tb_pc_stack_unit;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  // strobe vector bit order: {ret, call, load, br, inc}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_INC  = 5'b00001;
  localparam logic [4:0] S_BR   = 5'b00010;
  localparam logic [4:0] S_LOAD = 5'b00100;
  localparam logic [4:0] S_CALL = 5'b01000;
  localparam logic [4:0] S_RET  = 5'b10000;

`ifdef PC_REL_BRANCH_EN
  localparam bit BR_ON = 1'b1;
`else
  localparam bit BR_ON = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       inc_pc, load_pc, br_rel, call, ret, err_clr;
  logic [7:0] data_in;
  logic [5:0] offset;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_empty, stack_full, stk_ovf, stk_unf;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks;
  int    n_fail;
  event  chk_now;

  pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(4), .OFF_W(6)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_inc_pc      (inc_pc),
    .i_load_pc     (load_pc),
    .i_br_rel      (br_rel),
    .i_call        (call),
    .i_ret         (ret),
    .i_data_in     (data_in),
    .i_offset      (offset),
    .i_err_clr     (err_clr),
    .o_pc          (pc),
    .o_sp          (sp),
    .o_stack_empty (stack_empty),
    .o_stack_full  (stack_full),
    .o_stk_ovf     (stk_ovf),
    .o_stk_unf     (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] p, input logic [2:0] s,
                              input logic o, input logic u);
    exp_t e;
    e.pc    = p;
    e.sp    = s;
    e.empty = (s == 3'd0);
    e.full  = (s == 3'd4);
    e.ovf   = o;
    e.unf   = u;
    return e;
  endfunction

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(negedge clk or chk_now);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {pc, sp, stack_empty, stack_full, stk_ovf, stk_unf};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got pc=%h sp=%0d empty=%b full=%b ovf=%b unf=%b, expected pc=%h sp=%0d empty=%b full=%b ovf=%b unf=%b",
                   nm, a.pc, a.sp, a.empty, a.full, a.ovf, a.unf,
                   e.pc, e.sp, e.empty, e.full, e.ovf, e.unf);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [4:0] s,
                      input logic [7:0] d, input logic [5:0] off,
                      input logic clr, input exp_t e);
    @(negedge clk);
    {ret, call, load_pc, br_rel, inc_pc} = s;
    data_in = d;
    offset  = off;
    err_clr = clr;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    reset_n = 1'b0;
    {ret, call, load_pc, br_rel, inc_pc, err_clr} = '0;
    data_in = '0;
    offset  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    step("reset_state", S_NONE, 8'h00, 6'h00, 1'b0, mk(8'h00, 3'd0, 0, 0));
    step("inc_1",       S_INC,  8'h00, 6'h00, 1'b0, mk(8'h01, 3'd0, 0, 0));
    step("inc_2",       S_INC,  8'h00, 6'h00, 1'b0, mk(8'h02, 3'd0, 0, 0));
    step("inc_3",       S_INC,  8'h00, 6'h00, 1'b0, mk(8'h03, 3'd0, 0, 0));
    step("load_ff",     S_LOAD, 8'hFF, 6'h00, 1'b0, mk(8'hFF, 3'd0, 0, 0));
    step("inc_wrap",    S_INC,  8'h00, 6'h00, 1'b0, mk(8'h00, 3'd0, 0, 0));
    step("load_10",     S_LOAD, 8'h10, 6'h00, 1'b0, mk(8'h10, 3'd0, 0, 0));
    step("call_40",     S_CALL, 8'h40, 6'h00, 1'b0, mk(8'h40, 3'd1, 0, 0));
    step("ret_11",      S_RET,  8'h00, 6'h00, 1'b0, mk(8'h11, 3'd0, 0, 0));

    // Nested calls to overflow, then unwind to underflow.
    step("load_01",     S_LOAD, 8'h01, 6'h00, 1'b0, mk(8'h01, 3'd0, 0, 0));
    step("ncall_1",     S_CALL, 8'h02, 6'h00, 1'b0, mk(8'h02, 3'd1, 0, 0));
    step("ncall_2",     S_CALL, 8'h03, 6'h00, 1'b0, mk(8'h03, 3'd2, 0, 0));
    step("ncall_3",     S_CALL, 8'h04, 6'h00, 1'b0, mk(8'h04, 3'd3, 0, 0));
    step("ncall_4",     S_CALL, 8'h05, 6'h00, 1'b0, mk(8'h05, 3'd4, 0, 0));
    step("ncall_5_ovf", S_CALL, 8'h06, 6'h00, 1'b0, mk(8'h06, 3'd4, 1, 0));
    step("nret_1",      S_RET,  8'h00, 6'h00, 1'b0, mk(8'h05, 3'd3, 1, 0));
    step("nret_2",      S_RET,  8'h00, 6'h00, 1'b0, mk(8'h04, 3'd2, 1, 0));
    step("nret_3",      S_RET,  8'h00, 6'h00, 1'b0, mk(8'h03, 3'd1, 1, 0));
    step("nret_4",      S_RET,  8'h00, 6'h00, 1'b0, mk(8'h02, 3'd0, 1, 0));
    step("nret_5_unf",  S_RET,  8'h00, 6'h00, 1'b0, mk(8'h02, 3'd0, 1, 1));
    step("err_clr",     S_NONE, 8'h00, 6'h00, 1'b1, mk(8'h02, 3'd0, 0, 0));
    step("clr_vs_unf",  S_RET,  8'h00, 6'h00, 1'b1, mk(8'h02, 3'd0, 0, 1));
    step("err_clr_2",   S_NONE, 8'h00, 6'h00, 1'b1, mk(8'h02, 3'd0, 0, 0));

    // Simultaneous strobes.
    step("call_30",     S_CALL,                 8'h30, 6'h00, 1'b0, mk(8'h30, 3'd1, 0, 0));
    step("ret_call_inc", S_RET | S_CALL | S_INC, 8'h50, 6'h00, 1'b0, mk(8'h03, 3'd0, 0, 0));
    step("load_inc",    S_LOAD | S_INC,          8'h20, 6'h00, 1'b0, mk(8'h20, 3'd0, 0, 0));
    step("call_ld_inc", S_CALL | S_LOAD | S_INC, 8'h70, 6'h00, 1'b0, mk(8'h70, 3'd1, 0, 0));
    step("ret_inc",     S_RET | S_INC,           8'h00, 6'h00, 1'b0, mk(8'h21, 3'd0, 0, 0));

    // Relative branch (holds when the feature is compiled out).
    step("load_05",     S_LOAD, 8'h05, 6'h00, 1'b0, mk(8'h05, 3'd0, 0, 0));
    step("br_m2",       S_BR,   8'h00, 6'h3E, 1'b0, mk(BR_ON ? 8'h03 : 8'h05, 3'd0, 0, 0));
    step("load_02",     S_LOAD, 8'h02, 6'h00, 1'b0, mk(8'h02, 3'd0, 0, 0));
    step("br_m4_wrap",  S_BR,   8'h00, 6'h3C, 1'b0, mk(BR_ON ? 8'hFE : 8'h02, 3'd0, 0, 0));
    step("load_fe",     S_LOAD, 8'hFE, 6'h00, 1'b0, mk(8'hFE, 3'd0, 0, 0));
    step("br_p5_wrap",  S_BR,   8'h00, 6'h05, 1'b0, mk(BR_ON ? 8'h03 : 8'hFE, 3'd0, 0, 0));
    step("br_inc",      S_BR | S_INC,  8'h00, 6'h05, 1'b0, mk(BR_ON ? 8'h08 : 8'hFF, 3'd0, 0, 0));
    step("br_load",     S_BR | S_LOAD, 8'h44, 6'h05, 1'b0, mk(8'h44, 3'd0, 0, 0));

    // Build sp=3 with a flag set, then reset asynchronously mid-cycle.
    step("pre_unf",     S_RET,  8'h00, 6'h00, 1'b0, mk(8'h44, 3'd0, 0, 1));
    step("rcall_1",     S_CALL, 8'h10, 6'h00, 1'b0, mk(8'h10, 3'd1, 0, 1));
    step("rcall_2",     S_CALL, 8'h20, 6'h00, 1'b0, mk(8'h20, 3'd2, 0, 1));
    step("rcall_3",     S_CALL, 8'h30, 6'h00, 1'b0, mk(8'h30, 3'd3, 0, 1));

    @(negedge clk);
    {ret, call, load_pc, br_rel, inc_pc} = S_RET;
    err_clr = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(8'h00, 3'd0, 0, 0));
    name_q.push_back("async_reset");
    -> chk_now;

    @(negedge clk);
    {ret, call, load_pc, br_rel, inc_pc} = S_NONE;
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset",  S_NONE, 8'h00, 6'h00, 1'b0, mk(8'h00, 3'd0, 0, 0));
    step("post_rst_ret", S_RET, 8'h00, 6'h00, 1'b0, mk(8'h00, 3'd0, 0, 1));

    @(negedge clk);
    {ret, call, load_pc, br_rel, inc_pc, err_clr} = '0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
